multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: a  input  32  multiplicand; captured only when a start is accepted.
REQ-004 SHALL have port: b  input  32  multiplier; captured only when a start is accepted.
REQ-005 SHALL have port: start  input  1  request; accepted on an edge where start=1, busy=0, reset=0.
REQ-006 SHALL have port: symbol  input  1  captured with a/b; 1 = signed two's-complement, 0 = unsigned.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port: done  output  1  single-cycle pulse when a new result is presented.
REQ-009 SHALL have port: hi  output  32  upper 32 bits of the 64-bit product.
REQ-010 SHALL have port: lo  output  32  lower 32 bits of the 64-bit product.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, SIGN.
- IDLE -> RUN on accepted start.
- RUN -> SIGN after exactly 32 iterations.
- SIGN -> IDLE after 1 cycle.
REQ-012 SHALL on accepted start latch a, b and symbol.
- symbol=1: latch magnitudes |a| and |b|, plus result sign neg = a[31]^b[31].
- symbol=0: neg = 0.
REQ-013 SHALL in RUN perform one radix-2 shift-add step per cycle into a 64-bit accumulator, LSB of the multiplier first.
REQ-014 SHALL in SIGN write {hi,lo} = neg ? two's-complement negation of the accumulator : accumulator.
REQ-015 SHALL drive done=1 for exactly the one cycle following the SIGN cycle; done is 0 otherwise.
REQ-016 SHALL assert busy from the edge that accepts start through the SIGN cycle.
- Latency: start accepted at edge k, busy=1 for cycles k+1..k+33, busy=0 and done=1 at cycle k+34.
REQ-017 SHALL ignore start while busy=1; latched operands are unaffected by a/b/symbol changes during busy.
REQ-018 SHALL hold hi/lo at the previous result while busy, updating them only at the SIGN cycle; they then hold until the next completion.
REQ-019 SHALL treat magnitude of 0x8000_0000 as unsigned 0x8000_0000 (no overflow).
- Signed 0x8000_0000 * 0x8000_0000 = 0x4000_0000_0000_0000.
REQ-020 SHALL accept a new start on the cycle done=1; back-to-back operations are permitted.

Reset
REQ-021 SHALL on reset=1 at any edge force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear accumulator and latched operands.
REQ-022 SHALL give reset priority over start on the same edge; an operation in progress is aborted with no done pulse.

Configuration
REQ-023 SHALL support macro MULTIPLIER_ZERO_SKIP_EN.
- Defined: an accepted start with a==0 or b==0 goes IDLE -> SIGN directly; busy=1 for 1 cycle, done=1 at k+2, result 0.
- Undefined: every operation takes the full 33 busy cycles per REQ-016.

Verification
REQ-024 SHALL cover: unsigned a=0x8000_0000, b=0x7D5F_8A74 -> after 33 busy cycles, done=1, hi=0x3EAF_C53A, lo=0x0000_0000.
REQ-025 SHALL cover: signed same operands -> hi=0xC150_3AC6, lo=0x0000_0000.
REQ-026 SHALL cover: 0xFFFF_FFFF * 0xFFFF_FFFF.
- Unsigned -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- Signed -> hi=0x0000_0000, lo=0x0000_0001.
REQ-027 SHALL cover: start pulsed again with a=5, b=7 at busy cycle 10 -> ignored; original result delivered; no second done.
REQ-028 SHALL cover: reset=1 for one edge at busy cycle 12 -> busy=0, hi=lo=0 next cycle, no done pulse; a following start completes normally.
REQ-029 SHALL cover: a=0, b=0x1234_5678 unsigned -> hi=lo=0.
- MULTIPLIER_ZERO_SKIP_EN defined: busy high 1 cycle.
- Undefined: busy high 33 cycles.

Source files
------------

// File: rtl/multiplier_if.sv
// Operand/result bundle for the sequential 32x32 multiplier.
// Master drives a, b, symbol and start; slave returns busy, done and the product halves.
// No clock or reset inside; those stay as plain ports on the multiplier.
interface multiplier_if;
    logic [31:0] a;       // multiplicand
    logic [31:0] b;       // multiplier
    logic        start;   // request, taken only while idle
    logic        symbol;  // 1 = signed, 0 = unsigned
    logic        busy;    // operation in progress
    logic        done;    // one-cycle result pulse
    logic [31:0] hi;      // product bits 63:32
    logic [31:0] lo;      // product bits 31:0

    modport master (
        output a, b, start, symbol,
        input  busy, done, hi, lo
    );

    modport slave (
        input  a, b, start, symbol,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add 32x32 -> 64 multiplier, signed or unsigned.
// Latency: start at edge k, busy for cycles k+1..k+33, done pulse with new hi/lo at k+34.
// Backpressure: start is ignored while busy; a new start may be taken on the done cycle.
//
// Ports: clock, reset (synchronous, active-high); bus (multiplier_if.slave) carries
// a, b, symbol, start in and busy, done, hi, lo out.
// Optional macro MULTIPLIER_ZERO_SKIP_EN: a start with a zero operand jumps straight
// to the sign step (busy for one cycle, done at k+2).
module multiplier (
    input  logic        clock,
    input  logic        reset,
    multiplier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] acc;      // running sum of partial products
    logic [63:0] mcand;    // multiplicand magnitude, shifted left each step
    logic [31:0] mplr;     // multiplier magnitude, shifted right each step
    logic [4:0]  cnt;      // step index within RUN
    logic        neg;      // final result must be negated
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        accept;
    logic        zero_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign accept = bus.start && (state == IDLE);

`ifdef MULTIPLIER_ZERO_SKIP_EN
    assign zero_op = (bus.a == 32'd0) || (bus.b == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    // Negating 0x8000_0000 wraps back to 0x8000_0000, which read as unsigned is
    // exactly the magnitude we want, so no extra bit is needed.
    assign abs_a = (bus.symbol && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign abs_b = (bus.symbol && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_op ? SIGN : RUN;
                end
            end
            RUN: begin
                // cnt==31 is the 32nd step being executed this cycle
                if (cnt == 5'd31) begin
                    state_nxt = SIGN;
                end
            end
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplr   <= 32'd0;
            cnt    <= 5'd0;
            neg    <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= 64'd0;
                        mcand <= {32'd0, abs_a};
                        mplr  <= abs_b;
                        cnt   <= 5'd0;
                        neg   <= bus.symbol & (bus.a[31] ^ bus.b[31]);
                    end
                end
                RUN: begin
                    if (mplr[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 5'd1;
                end
                SIGN: begin
                    // result becomes visible together with done, one cycle after SIGN
                    {hi_r, lo_r} <= neg ? (64'd0 - acc) : acc;
                    done_r       <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed corner cases plus chained random
// operations, expected products queued at stimulus time and compared at done.
module tb_multiplier;

    logic clock;
    logic reset;
    multiplier_if mif ();

    multiplier dut (
        .clock (clock),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int fails     = 0;
    int done_cnt  = 0;
    logic [63:0] exp_q[$];

`ifdef MULTIPLIER_ZERO_SKIP_EN
    localparam int ZERO_BUSY = 1;
`else
    localparam int ZERO_BUSY = 33;
`endif

    always @(negedge clock) begin
        if (mif.done === 1'b1) done_cnt++;
    end

    // Reference product computed with native wide arithmetic.
    function automatic logic [63:0] model(input logic [31:0] ia, input logic [31:0] ib, input logic sym);
        logic signed [63:0] sa, sb;
        if (sym) begin
            sa = $signed({{32{ia[31]}}, ia});
            sb = $signed({{32{ib[31]}}, ib});
            return 64'(sa * sb);
        end
        return {32'd0, ia} * {32'd0, ib};
    endfunction

    // Called at a falling edge. Drives one start, scrambles inputs while busy, and
    // returns at the falling edge of the done cycle (or after the cycle budget).
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isym,
                         output logic [63:0] res, output int bcyc, output int hold_err,
                         output bit timeout);
        logic [63:0] prev;
        prev        = {mif.hi, mif.lo};
        mif.a       = ia;
        mif.b       = ib;
        mif.symbol  = isym;
        mif.start   = 1'b1;
        @(negedge clock);
        mif.start   = 1'b0;
        mif.a       = $urandom;
        mif.b       = $urandom;
        mif.symbol  = 1'($urandom);
        bcyc        = 0;
        hold_err    = 0;
        timeout     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (mif.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (mif.busy === 1'b1) begin
                bcyc++;
                if ({mif.hi, mif.lo} !== prev) hold_err++;
            end
            @(negedge clock);
        end
        res = {mif.hi, mif.lo};
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        mif.start  = 1'b0;
        mif.a      = 32'd3;
        mif.b      = 32'd4;
        mif.symbol = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", mif.busy); end
        tests_run++; if (mif.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", mif.done); end
        tests_run++; if (mif.hi !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 0", mif.hi); end
        tests_run++; if (mif.lo !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 0", mif.lo); end
        // start during reset must not be accepted
        mif.start = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        tests_run++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL reset_prio_busy got %b want 0", mif.busy); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One directed operation with full latency/hold checks against a queued expectation.
    task automatic test_case(input string name, input logic [31:0] ia, input logic [31:0] ib,
                             input logic isym, input logic [63:0] expv, input int exp_busy);
        logic [63:0] res, want;
        int bcyc, herr;
        bit to;
        exp_q.push_back(expv);
        do_op(ia, ib, isym, res, bcyc, herr, to);
        want = exp_q.pop_front();
        tests_run++; if (to) begin fails++; $display("FAIL %s_timeout no done within budget", name); end
        tests_run++; if (res !== want) begin fails++; $display("FAIL %s_result got %h want %h", name, res, want); end
        tests_run++; if (bcyc !== exp_busy) begin fails++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bcyc, exp_busy); end
        tests_run++; if (herr !== 0) begin fails++; $display("FAIL %s_hold got %0d changes want 0", name, herr); end
        tests_run++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL %s_busy_at_done got %b want 0", name, mif.busy); end
        @(negedge clock);
        tests_run++; if (mif.done !== 1'b0) begin fails++; $display("FAIL %s_done_width got %b want 0", name, mif.done); end
        tests_run++; if ({mif.hi, mif.lo} !== want) begin fails++; $display("FAIL %s_result_hold got %h want %h", name, {mif.hi, mif.lo}, want); end
    endtask

    task automatic test_directed;
        test_case("unsigned_min_x", 32'h8000_0000, 32'h7D5F_8A74, 1'b0, 64'h3EAF_C53A_0000_0000, 33);
        test_case("signed_min_x",   32'h8000_0000, 32'h7D5F_8A74, 1'b1, 64'hC150_3AC6_0000_0000, 33);
        test_case("unsigned_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33);
        test_case("signed_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 33);
        test_case("signed_min_sq",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33);
        test_case("signed_mixed",   32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 33);
    endtask

    task automatic test_zero;
        test_case("zero_a", 32'd0, 32'h1234_5678, 1'b0, 64'd0, ZERO_BUSY);
    endtask

    task automatic test_ignore_start;
        logic [63:0] want;
        int d0;
        bit to;
        exp_q.push_back(model(32'h0001_2345, 32'h00AB_CDEF, 1'b0));
        d0         = done_cnt;
        mif.a      = 32'h0001_2345;
        mif.b      = 32'h00AB_CDEF;
        mif.symbol = 1'b0;
        mif.start  = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        repeat (9) @(negedge clock);
        mif.a      = 32'd5;
        mif.b      = 32'd7;
        mif.start  = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (mif.done === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clock);
        end
        want = exp_q.pop_front();
        tests_run++; if (to) begin fails++; $display("FAIL ignore_start_timeout no done within budget"); end
        tests_run++; if ({mif.hi, mif.lo} !== want) begin fails++; $display("FAIL ignore_start_result got %h want %h", {mif.hi, mif.lo}, want); end
        repeat (40) @(negedge clock);
        tests_run++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL ignore_start_done_count got %0d want 1", done_cnt - d0); end
        tests_run++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL ignore_start_idle got %b want 0", mif.busy); end
    endtask

    task automatic test_mid_reset;
        int d0;
        d0         = done_cnt;
        mif.a      = 32'h0BAD_F00D;
        mif.b      = 32'h0000_1234;
        mif.symbol = 1'b0;
        mif.start  = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        repeat (11) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests_run++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got %b want 0", mif.busy); end
        tests_run++; if ({mif.hi, mif.lo} !== 64'd0) begin fails++; $display("FAIL mid_reset_result got %h want 0", {mif.hi, mif.lo}); end
        repeat (40) @(negedge clock);
        tests_run++; if (done_cnt !== d0) begin fails++; $display("FAIL mid_reset_done got %0d pulses want 0", done_cnt - d0); end
        test_case("after_reset", 32'h0000_0009, 32'hFFFF_FFF0, 1'b1, 64'hFFFF_FFFF_FFFF_FF70, 33);
    endtask

    // Chained operations: each new start lands on the previous done cycle.
    task automatic test_back_to_back;
        logic [63:0] res, want;
        logic [31:0] ra, rb;
        logic        rs;
        int bcyc, herr;
        bit to;
        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (n == 3) ra = 32'h8000_0000;
            if (n == 6) rb = 32'hFFFF_FFFF;
            exp_q.push_back(model(ra, rb, rs));
            do_op(ra, rb, rs, res, bcyc, herr, to);
            want = exp_q.pop_front();
            tests_run++;
            if (to || res !== want || bcyc !== 33 || herr !== 0) begin
                fails++;
                $display("FAIL b2b_%0d a=%h b=%h s=%b got %h/%0d cyc want %h/33 cyc (timeout=%b hold=%0d)",
                         n, ra, rb, rs, res, bcyc, want, to, herr);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset      = 1'b1;
        mif.start  = 1'b0;
        mif.a      = 32'd0;
        mif.b      = 32'd0;
        mif.symbol = 1'b0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_zero();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
